// File: rtl/my_design_pkg.sv
// Shared types and constants for the number-to-ASCII formatter.
package my_design_pkg;

  typedef enum logic [1:0] {
    RADIX_DEC = 2'd0,
    RADIX_BIN = 2'd1,
    RADIX_HEX = 2'd2,
    RADIX_OCT = 2'd3
  } radix_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h61;

  localparam int NAT_DEC_16 = 5;
  localparam int NAT_BIN_16 = 16;
  localparam int NAT_HEX_16 = 4;
  localparam int NAT_OCT_16 = 6;

  // Decimal digit count of the largest w-bit unsigned value (elaboration time only).
  function automatic int dec_digits(input int w);
    longint unsigned m;
    int n;
    m = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (m != 64'd0) begin
        n = n + 1;
        m = m / 64'd10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/my_design_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle, DATA_W cycles.
module my_design_bcd
  import my_design_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ND     = dec_digits(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_value,
  output logic [4*ND-1:0]   o_bcd,
  output logic              o_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_bin;
  logic [4*ND-1:0]   r_bcd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [4*ND-1:0]   w_adj;

  // Add-3 correction of every BCD digit that is five or more before the shift
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < ND; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end else begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4];
      end
    end
  end

  // Shift register and step counter; done pulses for one cycle after the last shift
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= {DATA_W{1'b0}};
      r_bcd  <= {(4*ND){1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_value;
      r_bcd  <= {(4*ND){1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_bcd <= {w_adj[4*ND-2:0], r_bin[DATA_W-1]};
      r_bin <= {r_bin[DATA_W-2:0], 1'b0};
      if (r_cnt == CNT_W'(DATA_W - 1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_bcd  = r_bcd;
  assign o_done = r_done;

endmodule

// File: rtl/my_design.sv
// Formats an unsigned value as an ASCII string (dec/bin/hex/oct) streamed one char per handshake.
// Optional MY_DESIGN_PRINT_EN adds a simulation-only print task and completed-string display.
module my_design
  import my_design_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int WID_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  input  logic [1:0]        in_radix,
  input  logic [WID_W-1:0]  in_width,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last
);

  localparam int ND      = dec_digits(DATA_W);
  localparam int NAT_DEC = ND;
  localparam int NAT_BIN = DATA_W;
  localparam int NAT_HEX = (DATA_W + 3) / 4;
  localparam int NAT_OCT = (DATA_W + 2) / 3;
  localparam int IDX_W   = ((WID_W > 6) ? WID_W : 6) + 1;
  localparam int CNT_W   = $clog2(DATA_W + 1);

  state_e            r_state;
  radix_e            r_radix;
  logic [DATA_W-1:0] r_value;
  logic [WID_W-1:0]  r_width;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_pos;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_last;
  logic [7:0]        r_out_char;

  logic              w_accept;
  logic              w_bcd_done;
  logic [4*ND-1:0]   w_bcd;
  logic [IDX_W-1:0]  w_sig;
  logic [IDX_W-1:0]  w_nat;
  logic [IDX_W-1:0]  w_field;
  logic [IDX_W-1:0]  w_len;
  logic [IDX_W-1:0]  w_pos_nxt;
  logic [3:0]        w_digit;
  logic [7:0]        w_char;

  assign w_accept = in_valid && r_in_ready;

  my_design_bcd #(.DATA_W(DATA_W), .ND(ND)) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept),
    .i_value (in_value),
    .o_bcd   (w_bcd),
    .o_done  (w_bcd_done)
  );

  // Digit k (0 = least significant); positions beyond the number read as zero
  function automatic logic [3:0] digit_at(input radix_e r, input logic [DATA_W-1:0] v,
                                          input logic [4*ND-1:0] b, input logic [IDX_W-1:0] k);
    logic [3:0] d;
    case (r)
      RADIX_DEC: d = 4'(b >> {k, 2'b00});
      RADIX_BIN: d = {3'b000, 1'(v >> k)};
      RADIX_HEX: d = 4'(v >> {k, 2'b00});
      RADIX_OCT: d = {1'b0, 3'(v >> ({2'b00, k} * (IDX_W+2)'(3)))};
      default:   d = 4'd0;
    endcase
    return d;
  endfunction

  // String layout: significant digits, field width and the next character to present
  always_comb begin
    w_sig = IDX_W'(1);
    for (int k = 0; k < DATA_W; k++) begin
      w_sig = (digit_at(r_radix, r_value, w_bcd, IDX_W'(k)) != 4'd0) ? IDX_W'(k + 1) : w_sig;
    end
    case (r_radix)
      RADIX_DEC: w_nat = IDX_W'(NAT_DEC);
      RADIX_BIN: w_nat = IDX_W'(NAT_BIN);
      RADIX_HEX: w_nat = IDX_W'(NAT_HEX);
      RADIX_OCT: w_nat = IDX_W'(NAT_OCT);
      default:   w_nat = IDX_W'(NAT_BIN);
    endcase
    w_field = (r_width == {WID_W{1'b1}}) ? w_nat : IDX_W'(r_width);
    if (r_width == {WID_W{1'b0}}) begin
      w_len = w_sig;
    end else begin
      w_len = (w_sig > w_field) ? w_sig : w_field;
    end
    w_pos_nxt = r_out_valid ? (r_pos - 1'b1) : (w_len - 1'b1);
    w_digit   = digit_at(r_radix, r_value, w_bcd, w_pos_nxt);
    if (w_pos_nxt >= w_sig) begin
      w_char = (r_radix == RADIX_DEC) ? ASCII_SPACE : ASCII_ZERO;
    end else if (w_digit < 4'd10) begin
      w_char = ASCII_ZERO + {4'd0, w_digit};
    end else begin
      w_char = ASCII_A + {4'd0, w_digit} - 8'd10;
    end
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_radix     <= RADIX_DEC;
      r_value     <= {DATA_W{1'b0}};
      r_width     <= {WID_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_pos       <= {IDX_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_char  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_value    <= in_value;
            r_radix    <= radix_e'(in_radix);
            r_width    <= in_width;
            r_cnt      <= {CNT_W{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state <= ST_EMIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_EMIT: begin
          // First EMIT cycle lays out the string once the BCD result has settled
          if (!r_out_valid) begin
            if (w_bcd_done) begin
              r_pos       <= w_pos_nxt;
              r_out_char  <= w_char;
              r_out_last  <= (w_pos_nxt == {IDX_W{1'b0}});
              r_out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_char  <= 8'h00;
              r_in_ready  <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_pos      <= w_pos_nxt;
              r_out_char <= w_char;
              r_out_last <= (w_pos_nxt == {IDX_W{1'b0}});
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_out_char  <= 8'h00;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign out_last  = r_out_last;

`ifdef MY_DESIGN_PRINT_EN
  string r_line;

  task automatic print();
    $display("I'm at %m");
  endtask

  // Accumulates accepted characters and reports each finished string
  always @(posedge clk) begin
    if (!rst_n) begin
      r_line = "";
    end else if (r_out_valid && out_ready) begin
      r_line = {r_line, $sformatf("%c", r_out_char)};
      if (r_out_last) begin
        $display("%m: \"%s\" at %0t", r_line, $time);
        r_line = "";
      end
    end
  end
`endif

endmodule

// File: tb/tb_my_design.sv
// Directed bench for my_design: string contents, justification, latency, backpressure, reset abort.
module tb_my_design;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic [1:0]  in_radix;
  logic [4:0]  in_width;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_char;
  logic        out_last;

  int n_checks;
  int n_errors;

  my_design #(.DATA_W(16), .WID_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_radix  (in_radix),
    .in_width  (in_width),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string got, input string exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", tag, got, exp);
    end
  endtask

  function automatic string s(input int v);
    return $sformatf("%0d", v);
  endfunction

  task automatic run_case(input string name, input logic [15:0] v, input logic [1:0] rdx,
                          input logic [4:0] w, input string exp, input int stall_idx, input bit poke);
    string      got;
    int         lat, idx, last_at, stalls, guard;
    bit         done, stable;
    logic [7:0] held;
    got = ""; lat = 0; idx = 0; last_at = -1; stalls = 0; guard = 0;
    done = 1'b0; stable = 1'b1; held = 8'h00;
    @(negedge clk);
    check({name, "_in_ready"}, s(in_ready), "1");
    in_value = v; in_radix = rdx; in_width = w; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      if (poke && (lat == 3 || lat == 9)) begin
        in_valid = 1'b1; in_value = 16'hffff; in_radix = 2'd1; in_width = 5'd0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, s(lat), "17");
    while (!done && guard < 200) begin
      if (out_valid) begin
        if (idx == stall_idx && stalls < 5) begin
          if (stalls == 0) held = out_char;
          else if (out_char !== held) stable = 1'b0;
          out_ready = 1'b0;
          stalls++;
        end else begin
          if (stalls > 0 && idx == stall_idx && out_char !== held) stable = 1'b0;
          out_ready = 1'b1;
          got = {got, $sformatf("%c", out_char)};
          if (out_last) begin
            last_at = idx;
            done = 1'b1;
          end
          idx++;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    check({name, "_string"}, got, exp);
    check({name, "_last_idx"}, s(last_at), s(exp.len() - 1));
    if (stall_idx >= 0) check({name, "_stall_stable"}, s(stable), "1");
    check({name, "_ready_after"}, s(in_ready), "1");
    check({name, "_valid_after"}, s(out_valid), "0");
  endtask

  task automatic reset_abort();
    int lat;
    int seen;
    lat = 0; seen = 0;
    @(negedge clk);
    in_value = 16'h001a; in_radix = 2'd2; in_width = 5'd31; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("abort_reach_emit", s(out_valid), "1");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_valid", s(out_valid), "0");
    check("abort_ready", s(in_ready), "1");
    check("abort_char", s(out_char), "0");
    check("abort_last", s(out_last), "0");
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_more_chars", s(seen), "0");
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_value = 16'h0000; in_radix = 2'd0;
    in_width = 5'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", s(in_ready), "1");
    check("rst_out_valid", s(out_valid), "0");
    check("rst_out_last", s(out_last), "0");
    check("rst_out_char", s(out_char), "0");
    rst_n = 1'b1;

    run_case("dec_w0",   16'h001a, 2'd0, 5'd0,  "26",               -1, 1'b0);
    run_case("dec_nat",  16'h001a, 2'd0, 5'd31, "   26",            -1, 1'b0);
    run_case("dec_w3",   16'h001a, 2'd0, 5'd3,  " 26",              -1, 1'b0);
    run_case("bin_w0",   16'h001a, 2'd1, 5'd0,  "11010",            -1, 1'b0);
    run_case("bin_nat",  16'h001a, 2'd1, 5'd31, "0000000000011010", -1, 1'b0);
    run_case("bin_w3",   16'h001a, 2'd1, 5'd3,  "11010",            -1, 1'b0);
    run_case("hex_w0",   16'h001a, 2'd2, 5'd0,  "1a",               -1, 1'b0);
    run_case("hex_nat",  16'h001a, 2'd2, 5'd31, "001a",             -1, 1'b0);
    run_case("hex_w3",   16'h001a, 2'd2, 5'd3,  "01a",              -1, 1'b0);
    run_case("hex_zero", 16'h0000, 2'd2, 5'd0,  "0",                -1, 1'b0);
    run_case("oct_nat",  16'h001a, 2'd3, 5'd31, "000032",           -1, 1'b0);
    run_case("dec_max7", 16'hffff, 2'd0, 5'd7,  "  65535",          -1, 1'b0);
    run_case("hex_ovf",  16'hffff, 2'd2, 5'd2,  "ffff",             -1, 1'b0);
    run_case("dec_zero", 16'h0000, 2'd0, 5'd31, "    0",            -1, 1'b0);
    run_case("dec_1000", 16'd1000, 2'd0, 5'd0,  "1000",             -1, 1'b0);
    run_case("stall",    16'd12345, 2'd0, 5'd31, "12345",            2, 1'b0);
    run_case("poke",     16'hbeef, 2'd2, 5'd0,  "beef",             -1, 1'b1);
    reset_abort();
    run_case("post_rst", 16'h001a, 2'd0, 5'd3,  " 26",              -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/my_design.md
MY_DESIGN -- requirements
Module: my_design

Interface
REQ-001 Parameter DATA_W, default 16, width of the unsigned input value (legal 4..32).
REQ-002 Parameter WID_W, default 5, width of the field-width input.
REQ-003 Port list:
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request strobe.
- in_ready  output  1  block idle and able to accept.
- in_value  input  DATA_W  unsigned number to format.
- in_radix  input  2  0=decimal, 1=binary, 2=hex, 3=octal.
- in_width  input  WID_W  field width: 0=minimal, all-ones=natural, else explicit.
- out_valid  output  1  character available.
- out_ready  input  1  consumer accepts character.
- out_char  output  8  ASCII character.
- out_last  output  1  marks final character of the string.

Function
REQ-004 Request SHALL be accepted on a cycle with in_valid=1 and in_ready=1; value, radix and width are captured.
REQ-005 FSM states SHALL be IDLE -> CONVERT -> EMIT -> IDLE; in_ready=1 only in IDLE; in_valid outside IDLE is ignored.
REQ-006 CONVERT SHALL last exactly DATA_W cycles for every radix; decimal uses shift-add-3 (double-dabble) BCD conversion.
REQ-007 First out_valid SHALL assert DATA_W+1 cycles after the accept edge.
REQ-008 Digits SHALL be most-significant first; hex digits lowercase '0'-'9','a'-'f'.
REQ-009 Width 0: no padding and no leading zeros; value 0 yields single "0".
REQ-010 Natural width (all-ones) SHALL equal the digit count of the maximum DATA_W value: 5 dec, 16 bin, 4 hex, 6 oct at DATA_W=16.
REQ-011 Explicit or natural width: right-justified; decimal padded with spaces (0x20), bin/hex/oct padded with '0'.
REQ-012 If significant digits exceed the width, all significant digits SHALL be emitted, never truncated.
REQ-013 In EMIT, out_char/out_last SHALL hold stable while out_valid=1 and out_ready=0; one character advances per handshake.
REQ-014 After the handshake of the out_last character, the block SHALL return to IDLE with in_ready=1 on the next cycle.

Reset
REQ-015 rst_n=0 at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, out_last=0, out_char=8'h00.
REQ-016 Reset during CONVERT or EMIT SHALL abort the string; no further characters are emitted.

Configuration
REQ-017 Macro MY_DESIGN_PRINT_EN defined: the module SHALL contain a simulation-only task print that displays "I'm at <hierarchical name>" via %m, callable hierarchically as <inst>.print. It SHALL also display each completed string with the sim time.
REQ-018 Macro undefined: no task, no display statements, and identical port behaviour.

Structure
REQ-019 Package my_design_pkg SHALL hold the radix enum, the FSM state enum, ASCII constants (space, '0', 'a'), and natural-width constants.
REQ-020 Sub-module my_design_bcd SHALL implement the DATA_W-cycle double-dabble converter (start, value in, BCD out, done).

Verification
REQ-021 Value 0x1a, decimal: width 0 -> "26"; natural -> "   26"; width 3 -> " 26", last on '6'.
REQ-022 Value 0x1a, binary: width 0 -> "11010"; natural -> "0000000000011010"; width 3 -> "11010".
REQ-023 Value 0x1a, hex: width 0 -> "1a"; natural -> "001a"; width 3 -> "01a"; value 0 width 0 -> "0".
REQ-024 out_ready held low 5 cycles mid-string -> out_char stable, no characters lost or duplicated.
REQ-025 rst_n low for one cycle during EMIT -> out_valid=0 next cycle, in_ready=1, next request formats correctly.
REQ-026 in_valid pulsed during CONVERT -> ignored; first out_valid exactly DATA_W+1 cycles after accept.
